moment_bank_ram: RTL
====================

Name: moment_bank_ram

Overview:
- Multi-channel moment store for the LBM core: NUM_CH parallel banks (default 3: rho, ux, uy), each DEPTH x DATA_WIDTH signed, sharing one address space.
- Successor to the single-channel, combinational-read moment store:
  - registered 1-cycle read with valid flag;
  - separate read and write ports;
  - per-channel write enables;
  - built-in clear/initialise sequencer that fills every cell with a per-channel initial value.
- Sits between the collision/streaming datapath and the moment output/display logic.

Parameters:
- DEPTH, 256, cells per channel (16x16 lattice).
- ADDRESS_WIDTH, $clog2(DEPTH), address width.
- DATA_WIDTH, 64, signed word width per channel.
- NUM_CH, 3, number of moment channels.
- INIT_VEC, all zeros (NUM_CH*DATA_WIDTH bits), per-channel fill value; channel c is bits [c*DATA_WIDTH +: DATA_WIDTH].
- INIT_ON_RESET, 1, when 1 a clear sequence starts automatically after Reset.

Ports:
- Clk  in  1  system clock, all logic on rising edge.
- Reset  in  1  synchronous, active-high.
- init_start  in  1  1-cycle request to (re)fill all cells with INIT_VEC.
- init_busy  out  1  high while clear sequence runs.
- init_done  out  1  1-cycle pulse on the cycle after the last clear write.
- wr_en  in  NUM_CH  per-channel write enable.
- wr_addr  in  ADDRESS_WIDTH  write address.
- wr_data  in  NUM_CH*DATA_WIDTH  packed write data, same channel packing as INIT_VEC.
- rd_en  in  1  read request.
- rd_addr  in  ADDRESS_WIDTH  read address.
- rd_data  out  NUM_CH*DATA_WIDTH  packed signed read data, registered.
- rd_valid  out  1  rd_data holds the result of the read accepted one cycle earlier.

Behaviour:
- Clocking and reset:
  - One clock domain.
  - Reset is synchronous, active-high, sampled on the Clk rising edge.
- Reset values:
  - init_done=0, rd_valid=0, rd_data=0, internal clear counter=0.
  - init_busy=1 if INIT_ON_RESET=1, otherwise 0.
  - Memory contents are not reset directly; they are defined only after a clear sequence or explicit writes.
- FSM states IDLE, CLEAR, DONE:
  - Reset -> CLEAR if INIT_ON_RESET, else IDLE.
  - IDLE & init_start -> CLEAR, counter=0.
  - CLEAR: each cycle writes INIT_VEC to all channels at address counter, then counter++.
  - CLEAR: when counter==DEPTH-1 the write happens and the FSM goes to DONE.
  - DONE: init_done=1 for exactly one cycle, then IDLE.
  - Full clear = DEPTH write cycles. init_busy=1 in CLEAR only.
- Clear sequence boundaries:
  - init_start while in CLEAR: ignored; no restart.
  - init_start in DONE: accepted, goes to CLEAR on the next edge. init_done still pulses in the DONE cycle.
  - Reset mid-CLEAR: counter returns to 0. The FSM re-enters CLEAR (INIT_ON_RESET=1) or IDLE. No init_done pulse for the aborted sequence.
- Writes:
  - When not in CLEAR, channel c is written with wr_data slice c at wr_addr if wr_en[c].
  - Channels with wr_en[c]=0 are unchanged.
  - During CLEAR, wr_en is ignored and user writes are dropped.
  - wr_addr >= DEPTH (non-power-of-2 DEPTH) is dropped with no effect.
- Reads:
  - rd_en=1 in cycle N (not in CLEAR) -> rd_data = mem[rd_addr] for all channels and rd_valid=1 in cycle N+1.
  - rd_en=0 -> rd_valid=0 next cycle; rd_data holds its last value.
  - rd_en during CLEAR -> request dropped; rd_valid=0 next cycle.
  - rd_addr >= DEPTH -> rd_data=0 with rd_valid=1.
  - Back-to-back reads every cycle are supported: throughput 1 read/cycle.
- Read/write same address, same cycle: read-old-data. rd_data returns the value before the write; the new value is visible to reads issued from the next cycle.
- Arithmetic: none. Data is stored and returned bit-exact; signedness is for the consumers' interpretation only.
- Memory must map to block RAM:
  - synchronous read;
  - no reset on the array;
  - no combinational whole-array output port.

Test Plan:
- Reset with INIT_ON_RESET=1, DEPTH=16, NUM_CH=3, INIT_VEC={64'd0,64'd0,64'd1000} -> init_busy high exactly 16 cycles, init_done pulses once. Reading addresses 0..15 then returns ch0=1000, ch1=0, ch2=0, with rd_valid one cycle after each rd_en.
- wr_en=3'b101 at addr 5, data {ch2=-7, ch1=99, ch0=42} after init -> read addr 5 returns ch0=42, ch1=0 (unchanged), ch2=-7 (sign-extended pattern 64'hFFFF_FFFF_FFFF_FFF9).
- Same-cycle write addr 3 = 55 (ch0) and read addr 3 -> rd_data ch0 = old value 1000. A read of addr 3 the next cycle returns 55.
- init_start mid-operation, then wr_en=3'b111 and rd_en issued during CLEAR -> writes dropped (addr written reads INIT_VEC after done), rd_valid stays 0 throughout CLEAR.
- Reset asserted at clear counter=7 -> counter restarts at 0, no init_done for the aborted run, a full 16-cycle clear follows with one init_done.
- Continuous reads of addresses 0..15 on 16 consecutive cycles -> rd_valid high 16 consecutive cycles starting one cycle later, data in address order.

Source files
------------

// File: rtl/moment_bank_ram.sv
// moment_bank_ram: multi-channel moment store for the LBM core.
// NUM_CH independent banks share one address space. Reads are registered with one cycle
// of latency. A built-in clear sequencer fills every cell with a per-channel INIT_VEC value.
module moment_bank_ram #(
    parameter int unsigned DEPTH         = 256,
    parameter int unsigned ADDRESS_WIDTH = $clog2(DEPTH),
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned NUM_CH        = 3,
    parameter logic [NUM_CH*DATA_WIDTH-1:0] INIT_VEC = '0,
    parameter bit          INIT_ON_RESET = 1'b1
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic                           init_start,
    output logic                           init_busy,
    output logic                           init_done,
    input  logic [NUM_CH-1:0]              wr_en,
    input  logic [ADDRESS_WIDTH-1:0]       wr_addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   wr_data,
    input  logic                           rd_en,
    input  logic [ADDRESS_WIDTH-1:0]       rd_addr,
    output logic [NUM_CH*DATA_WIDTH-1:0]   rd_data,
    output logic                           rd_valid
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);
    // One extra bit so DEPTH itself is representable for the range checks.
    localparam logic [ADDRESS_WIDTH:0]   DEPTH_EXT = (ADDRESS_WIDTH + 1)'(DEPTH);

    logic [1:0]               state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic                     clearing;
    logic                     wr_in_range;
    logic                     rd_in_range;
    logic                     rd_accept;
    logic                     rd_valid_q;
    logic [DATA_WIDTH-1:0]    rd_word [NUM_CH];

    assign clearing    = (state_q == ST_CLEAR);
    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_EXT);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_EXT);
    assign rd_accept   = rd_en && !clearing;

    assign init_busy = clearing;
    assign init_done = (state_q == ST_DONE);
    assign rd_valid  = rd_valid_q;

    // Clear sequencer next-state: walk the counter over every address, then pulse done.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (init_start) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end
            end
            ST_CLEAR: begin
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d   = ST_DONE;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                // A new request here restarts immediately; done still pulses this cycle.
                if (init_start) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                clr_cnt_d = '0;
            end
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= INIT_ON_RESET ? ST_CLEAR : ST_IDLE;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Read-valid flag: a read is accepted only outside the clear sequence.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_accept;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DATA_WIDTH-1:0]    mem [DEPTH];
        logic                     we;
        logic [ADDRESS_WIDTH-1:0] wa;
        logic [DATA_WIDTH-1:0]    wd;
        logic [DATA_WIDTH-1:0]    rd_word_q;

        // Write port mux: the clear sequencer owns the port while it runs.
        always_comb begin
            if (clearing) begin
                we = 1'b1;
                wa = clr_cnt_q;
                wd = INIT_VEC[c*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                we = wr_en[c] && wr_in_range;
                wa = wr_addr;
                wd = wr_data[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        // Array write; no reset so the bank maps onto block RAM.
        always_ff @(posedge Clk) begin
            if (we) begin
                mem[wa] <= wd;
            end
        end

        // Synchronous read; sampling before the write lands gives read-old-data.
        always_ff @(posedge Clk) begin
            if (Reset) begin
                rd_word_q <= '0;
            end else if (rd_accept) begin
                rd_word_q <= rd_in_range ? mem[rd_addr] : '0;
            end
        end

        assign rd_word[c] = rd_word_q;
    end

    // Pack the per-channel read registers onto the output bus.
    always_comb begin
        rd_data = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            rd_data[c*DATA_WIDTH +: DATA_WIDTH] = rd_word[c];
        end
    end

endmodule
